// File: rtl/sprite_blitter_if.sv
// Bus-initiator interface of the sprite blitter: one address/write-strobe
// channel toward memory and the read data and ready signals coming back.
interface sprite_blitter_if;
  logic [31:0] addr_bus;
  logic        mem_w;
  logic [31:0] Cpu_data2bus;
  logic        MIO_ready;
  logic [31:0] Cpu_data4bus;

  modport master (
    output addr_bus, mem_w, Cpu_data2bus,
    input  MIO_ready, Cpu_data4bus
  );

  modport slave (
    input  addr_bus, mem_w, Cpu_data2bus,
    output MIO_ready, Cpu_data4bus
  );
endinterface

// File: rtl/sprite_blitter.sv
// Copies a spr_w x spr_h sprite from source space into VRAM one pixel at a time,
// skipping key-coloured pixels and anything that falls off the screen.
module sprite_blitter #(
  parameter int          SCR_W     = 640,
  parameter int          SCR_H     = 480,
  parameter logic [11:0] KEY_COLOR = 12'h000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [13:0]            src_base,
  input  logic [9:0]             dst_x,
  input  logic [8:0]             dst_y,
  input  logic [5:0]             spr_w,
  input  logic [5:0]             spr_h,
  sprite_blitter_if.master       bus,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, NEXT, FIN} state_e;

  typedef struct packed {
    logic [13:0] src;
    logic [9:0]  dx;
    logic [8:0]  dy;
    logic [5:0]  w;
    logic [5:0]  h;
  } cmd_t;

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [5:0]  r_q, r_d, c_q, c_d;
  logic [11:0] pix_q, pix_d;

  logic [31:0] addr_d, wdata_d;
  logic        wr_d;

  // Positions are widened well past their final size so clipping never wraps.
  logic [19:0] src_idx;
  logic [31:0] dst_col, dst_row, dst_idx;
  logic        in_bounds, last_pix;
  logic [31:0] rd_addr, wr_addr;

  assign src_idx   = {6'd0, cmd_q.src} + 20'(r_q) * 20'(cmd_q.w) + 20'(c_q);
  assign dst_col   = 32'(cmd_q.dx) + 32'(c_q);
  assign dst_row   = 32'(cmd_q.dy) + 32'(r_q);
  assign dst_idx   = dst_row * 32'(SCR_W) + dst_col;
  assign in_bounds = (dst_col < 32'(SCR_W)) && (dst_row < 32'(SCR_H));
  assign last_pix  = (r_q == cmd_q.h - 6'd1) && (c_q == cmd_q.w - 6'd1);
  assign rd_addr   = 32'h3000_0000 | {16'd0, src_idx[13:0], 2'b00};
  assign wr_addr   = 32'h1000_0000 | {11'd0, dst_idx[18:0], 2'b00};

  logic unused_bits;
  assign unused_bits = ^{bus.Cpu_data4bus[31:12], src_idx[19:14], dst_idx[31:19]};

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    r_d     = r_q;
    c_d     = c_q;
    pix_d   = pix_q;
    addr_d  = 32'd0;
    wdata_d = 32'd0;
    wr_d    = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d   = '{src: src_base, dx: dst_x, dy: dst_y, w: spr_w, h: spr_h};
          r_d     = 6'd0;
          c_d     = 6'd0;
          state_d = (spr_w != 6'd0 && spr_h != 6'd0) ? RD_ADDR : FIN;
        end
      end
      RD_ADDR: begin
        addr_d  = rd_addr;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        addr_d  = rd_addr;
        pix_d   = bus.Cpu_data4bus[11:0];
        state_d = (pix_d != KEY_COLOR && in_bounds) ? WR : NEXT;
      end
      WR: begin
        addr_d  = wr_addr;
        wr_d    = 1'b1;
        wdata_d = {20'h0, pix_q};
        if (bus.MIO_ready) state_d = NEXT;
      end
      NEXT: begin
        if (c_q < cmd_q.w - 6'd1) begin
          c_d = c_q + 6'd1;
        end else begin
          c_d = 6'd0;
          r_d = r_q + 6'd1;
        end
        state_d = last_pix ? FIN : RD_ADDR;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.addr_bus     = addr_d;
  assign bus.mem_w        = wr_d;
  assign bus.Cpu_data2bus = wdata_d;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      r_q     <= 6'd0;
      c_q     <= 6'd0;
      pix_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      r_q     <= r_d;
      c_q     <= c_d;
      pix_q   <= pix_d;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a pixel-level model predicts writes and
// latency per blit, and a per-cycle monitor checks the bus protocol.
module tb_sprite_blitter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] src_base;
  logic [9:0]  dst_x;
  logic [8:0]  dst_y;
  logic [5:0]  spr_w, spr_h;
  logic        busy, done;

  sprite_blitter_if bus ();

  sprite_blitter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .dst_x    (dst_x),
    .dst_y    (dst_y),
    .spr_w    (spr_w),
    .spr_h    (spr_h),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] src_mem [16384];
  int          stall_cfg = 0;
  int          stall_seen;
  wr_t         obs_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.Cpu_data4bus = (bus.addr_bus[31:28] == 4'h3)
                            ? {20'hABCDE, src_mem[bus.addr_bus[15:2]]} : 32'hDEAD_BEEF;
  assign bus.MIO_ready    = (stall_seen >= stall_cfg);

  // Counts refused write cycles so only the first write of a blit is stalled.
  always @(posedge clk or posedge rst) begin
    if (rst)                               stall_seen <= 0;
    else if (start && !busy)               stall_seen <= 0;
    else if (bus.mem_w && !bus.MIO_ready)  stall_seen <= stall_seen + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Per-cycle protocol monitor; also records every accepted write.
  logic        prev_stall;
  logic [31:0] prev_addr, prev_data;
  int          hold;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      hold       = 0;
      obs_q.delete();
    end else begin
      if (start && !busy) begin
        obs_q.delete();
        hold = 0;
      end
      if (!busy) begin
        check("idle_addr", bus.addr_bus, 32'd0);
        check("idle_memw", {31'd0, bus.mem_w}, 32'd0);
        check("idle_data", bus.Cpu_data2bus, 32'd0);
      end
      if (done) begin
        check("fin_addr", bus.addr_bus, 32'd0);
        check("fin_memw", {31'd0, bus.mem_w}, 32'd0);
      end
      if (bus.mem_w) check("wr_space", {28'd0, bus.addr_bus[31:28]}, 32'd1);
      if (prev_stall) begin
        check("stall_memw", {31'd0, bus.mem_w}, 32'd1);
        check("stall_addr", bus.addr_bus, prev_addr);
        check("stall_data", bus.Cpu_data2bus, prev_data);
      end
      if (bus.mem_w) hold++;
      if (bus.mem_w && bus.MIO_ready) begin
        obs_q.push_back('{addr: bus.addr_bus, data: bus.Cpu_data2bus, hold: hold});
        hold = 0;
      end
      prev_stall = bus.mem_w && !bus.MIO_ready;
      prev_addr  = bus.addr_bus;
      prev_data  = bus.Cpu_data2bus;
    end
  end

  // Model: walk the sprite in row-major order using plain screen arithmetic.
  task automatic model(input int s, x, y, w, h, stall, output wr_t exp_q[$], output int lat);
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        int          idx = (s + r * w + c) % 16384;
        logic [11:0] p   = src_mem[idx];
        if (p != 12'h000 && x + c < 640 && y + r < 480)
          exp_q.push_back('{addr: 32'h1000_0000 + 32'((y + r) * 640 + x + c) * 4,
                            data: {20'd0, p}, hold: 1});
      end
    if (w == 0 || h == 0) lat = 1;
    else lat = 1 + 3 * w * h + exp_q.size() + ((exp_q.size() > 0) ? stall : 0);
  endtask

  task automatic run_blit(input string tag, input logic [13:0] s, input logic [9:0] x,
                          input logic [8:0] y, input logic [5:0] w, input logic [5:0] h,
                          input int stall, input int lat_lit, input int nw_lit, input bit poke);
    wr_t exp_q[$];
    int  exp_lat, n, busy_bad;
    bit  got;
    model(int'(s), int'(x), int'(y), int'(w), int'(h), stall, exp_q, exp_lat);
    stall_cfg = stall;
    @(posedge clk); #1;
    src_base = s; dst_x = x; dst_y = y; spr_w = w; spr_h = h; start = 1'b1;
    n = 0; busy_bad = 0; got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (n >= 1 && !busy) busy_bad++;
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n == 1) begin
        src_base = ~s; dst_x = ~x; dst_y = ~y; spr_w = ~w; spr_h = ~h;
      end
      if (poke && n == 5) start = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_lat_model"}, n, exp_lat);
    check({tag, "_lat_lit"}, n, lat_lit);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_nwr_model"}, obs_q.size(), exp_q.size());
    check({tag, "_nwr_lit"}, obs_q.size(), nw_lit);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_wr_addr"}, obs_q[i].addr, exp_q[i].addr);
      check({tag, "_wr_data"}, obs_q[i].data, exp_q[i].data);
    end
    @(negedge clk);
    check({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_post_done"}, {31'd0, done}, 32'd0);
    stall_cfg = 0;
  endtask

  initial begin
    int ndone;
    bit seen;
    rst = 1'b1; start = 1'b0;
    src_base = '0; dst_x = '0; dst_y = '0; spr_w = '0; spr_h = '0;
    for (int i = 0; i < 16384; i++) src_mem[i] = 12'((i * 7) & 12'hFFF) | 12'h800;
    src_mem[16'h10] = 12'h111; src_mem[16'h11] = 12'h222;
    src_mem[16'h12] = 12'h333; src_mem[16'h13] = 12'h444;
    #1;
    check("rst_addr", bus.addr_bus, 32'd0);
    check("rst_memw", {31'd0, bus.mem_w}, 32'd0);
    check("rst_data", bus.Cpu_data2bus, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic 2x2 at (2,3); a second start mid-blit must not disturb it.
    run_blit("basic", 14'h010, 10'd2, 9'd3, 6'd2, 6'd2, 0, 17, 4, 1'b1);
    check("basic_first_addr", obs_q[0].addr, 32'h1000_1E08);
    check("basic_first_data", obs_q[0].data, 32'h0000_0111);
    check("basic_last_addr", obs_q[3].addr, 32'h1000_280C);
    check("basic_hold", obs_q[0].hold, 1);

    src_mem[16'h11] = 12'h000;
    run_blit("transp", 14'h010, 10'd2, 9'd3, 6'd2, 6'd2, 0, 16, 3, 1'b0);
    check("transp_second_addr", obs_q[1].addr, 32'h1000_2808);
    src_mem[16'h11] = 12'h222;

    run_blit("stall", 14'h010, 10'd2, 9'd3, 6'd2, 6'd2, 5, 22, 4, 1'b0);
    check("stall_hold", obs_q[0].hold, 6);

    run_blit("clip", 14'h100, 10'd638, 9'd479, 6'd4, 6'd2, 0, 27, 2, 1'b0);
    check("clip_addr1", obs_q[1].addr, 32'h1000_0000 + 32'(479 * 640 + 639) * 4);

    run_blit("wrap", 14'h3FFF, 10'd0, 9'd0, 6'd2, 6'd1, 0, 9, 2, 1'b0);
    check("wrap_data2", obs_q[1].data, 32'h0000_0800);

    run_blit("zero_w", 14'h010, 10'd2, 9'd3, 6'd0, 6'd5, 0, 1, 0, 1'b0);
    run_blit("zero_h", 14'h010, 10'd2, 9'd3, 6'd5, 6'd0, 0, 1, 0, 1'b0);

    // Reset during a write stall must abort at once with no done pulse.
    stall_cfg = 1000;
    @(posedge clk); #1;
    src_base = 14'h010; dst_x = 10'd2; dst_y = 9'd3; spr_w = 6'd2; spr_h = 6'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_w) begin seen = 1'b1; break; end
    end
    check("abort_wr_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("abort_memw", {31'd0, bus.mem_w}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_addr", bus.addr_bus, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stall_cfg = 0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    run_blit("fresh", 14'h010, 10'd2, 9'd3, 6'd2, 6'd2, 0, 17, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
